// File: rtl/metrics_pkg.sv
// Shared widths, display-mode encoding and helpers for the latency statistics block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package metrics_pkg;

  localparam int LATENCY_WIDTH = 24;
  localparam int COUNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    DISP_LAST = 2'd0,
    DISP_MIN  = 2'd1,
    DISP_MAX  = 2'd2,
    DISP_AVG  = 2'd3
  } disp_mode_t;

  // Running minimum starts at the largest representable latency so the
  // first real sample always replaces it.
  localparam logic [LATENCY_WIDTH-1:0] MIN_INIT = '1;

endpackage

// File: rtl/metrics_window_avg.sv
// Windowed average of latency samples over 2^AVG_LOG2 samples (truncating).
// Latency: avg_value updates on the edge that captures the final sample of a window.
// Backpressure: none; accepts one sample per cycle, clear discards the partial window.
module metrics_window_avg
  import metrics_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     sample_valid,
  input  logic [LATENCY_WIDTH-1:0] sample_value,
  input  logic                     clear,
  output logic [LATENCY_WIDTH-1:0] avg_value
);

  // Accumulator carries AVG_LOG2 extra bits so a full window of maximum
  // samples cannot overflow.
  localparam int ACC_W = LATENCY_WIDTH + AVG_LOG2;

  logic [ACC_W-1:0]         acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0]      win_cnt_q, win_cnt_d;
  logic [LATENCY_WIDTH-1:0] avg_q, avg_d;

  // Accumulate samples; on the last sample of a window publish the mean and restart.
  always_comb begin
    sum       = acc_q + ACC_W'(sample_value);
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    avg_d     = avg_q;
    if (clear) begin
      acc_d     = '0;
      win_cnt_d = '0;
      avg_d     = '0;
    end else if (sample_valid) begin
      if (win_cnt_q == '1) begin
        avg_d     = sum[ACC_W-1:AVG_LOG2];
        acc_d     = '0;
        win_cnt_d = '0;
      end else begin
        acc_d     = sum;
        win_cnt_d = win_cnt_q + AVG_LOG2'(1);
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_q     <= '0;
      win_cnt_q <= '0;
      avg_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      avg_q     <= avg_d;
    end
  end

  assign avg_value = avg_q;

endmodule

// File: rtl/latency_stats_scheduler.sv
// Last/min/max/avg latency statistics and display-mode scheduler for the HEX display.
// Latency: statistics update on the capture edge; disp_value follows one cycle later.
// Backpressure: none; full-rate samples. Optional METRICS_AUTO_ROTATE_EN adds a dwell rotate timer.
module latency_stats_scheduler
  import metrics_pkg::*;
#(
  parameter int AVG_LOG2      = 3,
  parameter int ROTATE_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     sample_valid,
  input  logic [LATENCY_WIDTH-1:0] sample_value,
  input  logic                     clear,
  input  logic                     mode_next,
  output logic [LATENCY_WIDTH-1:0] disp_value,
  output logic [1:0]               disp_mode,
  output logic                     stats_valid,
  output logic [COUNT_WIDTH-1:0]   sample_count
);

  logic [LATENCY_WIDTH-1:0] last_q, last_d;
  logic [LATENCY_WIDTH-1:0] min_q, min_d;
  logic [LATENCY_WIDTH-1:0] max_q, max_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                     vld_q, vld_d;
  logic [LATENCY_WIDTH-1:0] disp_q, disp_d;
  logic [LATENCY_WIDTH-1:0] avg_value;
  disp_mode_t               mode_q, mode_d;
  logic                     advance;

  metrics_window_avg #(
    .AVG_LOG2     (AVG_LOG2)
  ) u_window_avg (
    .clk          (clk),
    .rst_l        (rst_l),
    .sample_valid (sample_valid),
    .sample_value (sample_value),
    .clear        (clear),
    .avg_value    (avg_value)
  );

`ifdef METRICS_AUTO_ROTATE_EN
  logic [31:0] dwell_q, dwell_d;
  logic        dwell_exp;

  // Dwell timer: expiry and mode_next both advance once and restart the count.
  always_comb begin
    dwell_exp = (dwell_q == 32'(ROTATE_CYCLES - 1));
    advance   = mode_next | dwell_exp;
    dwell_d   = advance ? 32'd0 : dwell_q + 32'd1;
  end

  // Dwell counter register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end
`else
  logic rotate_unused;
  assign rotate_unused = (ROTATE_CYCLES == 0);
  assign advance       = mode_next;
`endif

  // Statistics update: clear wins over a same-cycle sample.
  always_comb begin
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (clear) begin
      last_d = '0;
      min_d  = MIN_INIT;
      max_d  = '0;
      cnt_d  = '0;
      vld_d  = 1'b0;
    end else if (sample_valid) begin
      last_d = sample_value;
      if (sample_value < min_q) min_d = sample_value;
      if (sample_value > max_q) max_d = sample_value;
      vld_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
  end

  // Mode FSM next state: rotate LAST -> MIN -> MAX -> AVG -> LAST, independent of clear.
  always_comb begin
    mode_d = mode_q;
    if (advance) begin
      unique case (mode_q)
        DISP_LAST: mode_d = DISP_MIN;
        DISP_MIN:  mode_d = DISP_MAX;
        DISP_MAX:  mode_d = DISP_AVG;
        DISP_AVG:  mode_d = DISP_LAST;
        default:   mode_d = DISP_LAST;
      endcase
    end
  end

  // Output mux from registered state; MIN hides its all-ones seed until a sample exists.
  always_comb begin
    disp_d = '0;
    unique case (mode_q)
      DISP_LAST: disp_d = last_q;
      DISP_MIN:  disp_d = vld_q ? min_q : '0;
      DISP_MAX:  disp_d = max_q;
      DISP_AVG:  disp_d = avg_value;
      default:   disp_d = '0;
    endcase
  end

  // Statistic, mode and display registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_q <= '0;
      min_q  <= MIN_INIT;
      max_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      mode_q <= DISP_LAST;
      disp_q <= '0;
    end else begin
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      mode_q <= mode_d;
      disp_q <= disp_d;
    end
  end

  assign disp_value   = disp_q;
  assign disp_mode    = mode_q;
  assign stats_valid  = vld_q;
  assign sample_count = cnt_q;

endmodule
